// File: rtl/seq_mul_unit.sv
// Multi-cycle shift-add multiplier (MUL, MLA, UMULL, SMULL) with register-bank writeback.
// One multiplier bit per cycle; long results write back low word then high word.
module seq_mul_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] acc,
   input  logic [3:0]       wa_lo,
   input  logic [3:0]       wa_hi,
   output logic             busy,
   output logic             done,
   output logic             wb_we,
   output logic [3:0]       wb_wa,
   output logic [WIDTH-1:0] wb_wd
);

   localparam int unsigned PW = 2 * WIDTH;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CALC  = 2'd1;
   localparam logic [1:0] S_WB_LO = 2'd2;
   localparam logic [1:0] S_WB_HI = 2'd3;

   localparam logic [1:0] OP_MUL   = 2'b00;
   localparam logic [1:0] OP_MLA   = 2'b01;
   localparam logic [1:0] OP_UMULL = 2'b10;
   localparam logic [1:0] OP_SMULL = 2'b11;

   localparam logic [3:0] REG_PC = 4'hF;

   logic [1:0]       state_q,  state_nxt;
   logic [CNT_W-1:0] cnt_q,    cnt_nxt;
   logic [1:0]       op_q,     op_nxt;
   logic             neg_q,    neg_nxt;
   logic [WIDTH-1:0] acc_q,    acc_nxt;
   logic [3:0]       wlo_q,    wlo_nxt;
   logic [3:0]       whi_q,    whi_nxt;
   logic [PW-1:0]    mcand_q,  mcand_nxt;
   logic [WIDTH-1:0] mplr_q,   mplr_nxt;
   logic [PW-1:0]    prod_q,   prod_nxt;

   logic             busy_nxt, done_nxt, wb_we_nxt;
   logic [3:0]       wb_wa_nxt;
   logic [WIDTH-1:0] wb_wd_nxt;

   logic [PW-1:0]    sum_c;
   logic [WIDTH-1:0] a_sel_c, b_sel_c;
   logic             long_c;

   // Next-state, datapath and next-output logic
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      op_nxt    = op_q;
      neg_nxt   = neg_q;
      acc_nxt   = acc_q;
      wlo_nxt   = wlo_q;
      whi_nxt   = whi_q;
      mcand_nxt = mcand_q;
      mplr_nxt  = mplr_q;
      prod_nxt  = prod_q;
      sum_c     = prod_q;
      a_sel_c   = a;
      b_sel_c   = b;
      long_c    = 1'b0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
      wb_we_nxt = 1'b0;
      wb_wa_nxt = 4'h0;
      wb_wd_nxt = '0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               // Signed multiply runs on magnitudes; sign is re-applied at the end
               if (op == OP_SMULL) begin
                  a_sel_c = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
                  b_sel_c = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
                  neg_nxt = a[WIDTH-1] ^ b[WIDTH-1];
               end else begin
                  neg_nxt = 1'b0;
               end
               op_nxt    = op;
               acc_nxt   = acc;
               wlo_nxt   = wa_lo;
               whi_nxt   = wa_hi;
               mcand_nxt = PW'(a_sel_c);
               mplr_nxt  = b_sel_c;
               prod_nxt  = '0;
               cnt_nxt   = '0;
               state_nxt = S_CALC;
            end
         end
         S_CALC: begin
            sum_c     = mplr_q[0] ? (prod_q + mcand_q) : prod_q;
            prod_nxt  = sum_c;
            mcand_nxt = mcand_q << 1;
            mplr_nxt  = mplr_q >> 1;
            cnt_nxt   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_nxt = S_WB_LO;
               if (op_q == OP_SMULL && neg_q) begin
                  prod_nxt = ~sum_c + PW'(1);
               end
               if (op_q == OP_MLA) begin
                  prod_nxt[WIDTH-1:0] = sum_c[WIDTH-1:0] + acc_q;
               end
            end
         end
         S_WB_LO: begin
            state_nxt = (op_q == OP_UMULL || op_q == OP_SMULL) ? S_WB_HI : S_IDLE;
         end
         S_WB_HI: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      // Outputs are registered, so they follow the state being entered
      long_c   = (op_nxt == OP_UMULL) || (op_nxt == OP_SMULL);
      busy_nxt = (state_nxt != S_IDLE);
      case (state_nxt)
         S_WB_LO: begin
            wb_we_nxt = (wlo_nxt != REG_PC);
            wb_wa_nxt = wlo_nxt;
            wb_wd_nxt = prod_nxt[WIDTH-1:0];
            done_nxt  = !long_c;
         end
         S_WB_HI: begin
            wb_we_nxt = (whi_nxt != REG_PC);
            wb_wa_nxt = whi_nxt;
            wb_wd_nxt = prod_nxt[PW-1:WIDTH];
            done_nxt  = 1'b1;
         end
         default: begin
            wb_we_nxt = 1'b0;
         end
      endcase
   end

   // State and output registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= 2'b00;
         neg_q   <= 1'b0;
         acc_q   <= '0;
         wlo_q   <= 4'h0;
         whi_q   <= 4'h0;
         mcand_q <= '0;
         mplr_q  <= '0;
         prod_q  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         wb_we   <= 1'b0;
         wb_wa   <= 4'h0;
         wb_wd   <= '0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         op_q    <= op_nxt;
         neg_q   <= neg_nxt;
         acc_q   <= acc_nxt;
         wlo_q   <= wlo_nxt;
         whi_q   <= whi_nxt;
         mcand_q <= mcand_nxt;
         mplr_q  <= mplr_nxt;
         prod_q  <= prod_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
         wb_we   <= wb_we_nxt;
         wb_wa   <= wb_wa_nxt;
         wb_wd   <= wb_wd_nxt;
      end
   end

endmodule

// File: tb/tb_seq_mul_unit.sv
// Scoreboard bench for seq_mul_unit: stimulus pushes expected writeback events,
// a negedge monitor pops and compares whenever wb_we or done is seen.
module tb_seq_mul_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = '0, b = '0, acc = '0;
   logic [3:0]  wa_lo = '0, wa_hi = '0;
   logic        busy, done, wb_we;
   logic [3:0]  wb_wa;
   logic [31:0] wb_wd;

   typedef struct {
      logic        we;
      logic [3:0]  wa;
      logic [31:0] wd;
      logic        dn;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   seq_mul_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .acc(acc),
      .wa_lo(wa_lo), .wa_hi(wa_hi), .busy(busy), .done(done), .wb_we(wb_we),
      .wb_wa(wb_wa), .wb_wd(wb_wd)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: any write or done pulse must match the head of the scoreboard
   always @(negedge clk) begin
      if (wb_we || done) begin
         checks = checks + 1;
         if (q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_event cyc=%0d act we=%0b wa=%0d wd=%08h done=%0b req none",
                     cyc, wb_we, wb_wa, wb_wd, done);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (wb_we !== e.we || wb_wa !== e.wa || wb_wd !== e.wd || done !== e.dn || cyc != e.cyc) begin
               errors = errors + 1;
               $display("FAIL wb_event act we=%0b wa=%0d wd=%08h done=%0b cyc=%0d req we=%0b wa=%0d wd=%08h done=%0b cyc=%0d",
                        wb_we, wb_wa, wb_wd, done, cyc, e.we, e.wa, e.wd, e.dn, e.cyc);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks = checks + 1;
      if (act !== req) begin
         errors = errors + 1;
         $display("FAIL %s act=%0h req=%0h", name, act, req);
      end
   endtask

   task automatic chk_idle_outputs(input string name);
      chk(name, {busy, done, wb_we, wb_wa, wb_wd}, 64'h0);
   endtask

   // Drive a one-cycle start; n is the negedge cycle count just before E0
   task automatic drive(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] accv, input logic [3:0] lo, input logic [3:0] hi,
                        output int n);
      @(negedge clk);
      n = cyc;
      start = 1'b1; op = o; a = av; b = bv; acc = accv; wa_lo = lo; wa_hi = hi;
      @(negedge clk);
      start = 1'b0;
      a = $urandom; b = $urandom; acc = $urandom;
      chk("busy_after_start", 64'(busy), 64'h1);
   endtask

   task automatic wait_idle(input int n, input int lat);
      for (int i = 0; i < 80 && busy; i++) @(negedge clk);
      chk("busy_fall_cycle", 64'(cyc - n), 64'(lat));
      chk_idle_outputs("idle_outputs");
   endtask

   // Issue one op with hand-computed lo/hi words and queue the expected writebacks
   task automatic issue(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] accv, input logic [3:0] lo, input logic [3:0] hi,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi);
      int   n;
      exp_t e;
      logic lng;
      lng = o[1];
      drive(o, av, bv, accv, lo, hi, n);
      if (lng) begin
         if (lo != 4'hF) begin
            e.we = 1'b1; e.wa = lo; e.wd = exp_lo; e.dn = 1'b0; e.cyc = n + 33;
            q.push_back(e);
         end
         e.we = (hi != 4'hF); e.wa = hi; e.wd = exp_hi; e.dn = 1'b1; e.cyc = n + 34;
         q.push_back(e);
         wait_idle(n, 35);
      end else begin
         e.we = (lo != 4'hF); e.wa = lo; e.wd = exp_lo; e.dn = 1'b1; e.cyc = n + 33;
         q.push_back(e);
         wait_idle(n, 34);
      end
   endtask

   initial begin
      int n;
      rst = 1'b0;
      start = 1'b1;
      repeat (3) @(negedge clk);
      chk_idle_outputs("reset_outputs");
      start = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk_idle_outputs("post_reset_idle");

      issue(2'b00, 32'd7, 32'd6, 32'd0, 4'd3, 4'd0, 32'd42, 32'd0);
      issue(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 4'd4, 4'd5, 32'h00000001, 32'hFFFFFFFE);
      issue(2'b11, 32'hFFFFFFFE, 32'd3, 32'd0, 4'd1, 4'd2, 32'hFFFFFFFA, 32'hFFFFFFFF);
      issue(2'b11, 32'h80000000, 32'h80000000, 32'd0, 4'd1, 4'd2, 32'h00000000, 32'h40000000);
      issue(2'b11, 32'd5, 32'hFFFFFFF9, 32'd0, 4'd8, 4'd10, 32'hFFFFFFDD, 32'hFFFFFFFF);
      issue(2'b01, 32'h00010000, 32'h00010000, 32'd5, 4'd6, 4'd0, 32'h00000005, 32'd0);
      issue(2'b01, 32'd3, 32'd4, 32'hFFFFFFFF, 4'd6, 4'd0, 32'h0000000B, 32'd0);
      issue(2'b10, 32'd3, 32'd5, 32'd0, 4'd9, 4'd9, 32'h0000000F, 32'h00000000);
      issue(2'b10, 32'h00010000, 32'h00010000, 32'd0, 4'd15, 4'd7, 32'h00000000, 32'h00000001);
      issue(2'b00, 32'd9, 32'd9, 32'd0, 4'd15, 4'd0, 32'd81, 32'd0);

      // Ignored second start, then reset mid-CALC drops the writeback
      drive(2'b00, 32'd7, 32'd6, 32'd0, 4'd3, 4'd0, n);
      repeat (n + 10 - cyc) @(negedge clk);
      start = 1'b1; op = 2'b10; a = 32'd11; b = 32'd13; wa_lo = 4'd12; wa_hi = 4'd13;
      @(negedge clk);
      start = 1'b0;
      chk("busy_during_ignored_start", 64'(busy), 64'h1);
      repeat (n + 15 - cyc) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk_idle_outputs("mid_op_reset");
      repeat (40) @(negedge clk);
      chk("no_pending_after_reset", 64'(busy), 64'h0);

      issue(2'b00, 32'd2, 32'd2, 32'd0, 4'd3, 4'd0, 32'd4, 32'd0);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 64'(q.size()), 64'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_mul_unit.md
Name: seq_mul_unit

Overview:
Multi-cycle shift-add multiply unit for the execute stage. Operands come from the register bank read ports (rd1/rd2, plus a third read for accumulate). Results return to the register bank over a single-port write interface (we/addr/data), one 32-bit word per cycle. It supports MUL, MLA, UMULL and SMULL. Long results take two consecutive writeback cycles.

Parameters:
WIDTH, 32, operand width; the product is 2*WIDTH bits wide.
CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-low (0 = reset), sampled on rising edge of clk
start  input  1  request pulse; accepted only in IDLE
op  input  2  00 MUL, 01 MLA, 10 UMULL, 11 SMULL
a  input  WIDTH  multiplicand (Rm)
b  input  WIDTH  multiplier (Rs)
acc  input  WIDTH  accumulate operand (Rn), used by MLA only
wa_lo  input  4  destination register for low word (RdLo / Rd)
wa_hi  input  4  destination register for high word (RdHi), long ops only
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse in the final writeback cycle
wb_we  output  1  register bank write enable
wb_wa  output  4  register bank write address
wb_wd  output  WIDTH  register bank write data

Behaviour:
- States: IDLE, CALC, WB_LO, WB_HI.
- Reset (rst=0 at edge): state=IDLE, counter=0, product/operand registers=0. All outputs then read busy=0, done=0, wb_we=0, wb_wa=0, wb_wd=0. Reset overrides start in the same cycle.
- IDLE: on an edge with start=1, capture op, a, b, acc, wa_lo, wa_hi, then go to CALC with counter=0.
  - SMULL: capture |a| and |b|, and store neg = a[WIDTH-1]^b[WIDTH-1].
  - All other ops: capture operands unmodified (unsigned).
- CALC: one multiplier bit per cycle, LSB first. If the current bit is set, add the shifted multiplicand into the 2*WIDTH product register. Counter increments each cycle.
  - Exactly WIDTH cycles, then go to WB_LO.
  - On the transition out of CALC:
    - SMULL with neg=1: replace the product with its two's complement.
    - MLA: low word = product[WIDTH-1:0] + acc, modulo 2^WIDTH.
- WB_LO: wb_we=1, wb_wa=wa_lo, wb_wd=product low word.
  - MUL/MLA: done=1, next state IDLE.
  - UMULL/SMULL: done=0, next state WB_HI.
- WB_HI: wb_we=1, wb_wa=wa_hi, wb_wd=product high word, done=1, next state IDLE.
- Latency (start sampled at edge E0):
  - CALC occupies the cycles after E0..E31.
  - WB_LO is the cycle between E32 and E33; the register write lands at E33.
  - Long ops: WB_HI write lands at E34.
  - A new start is accepted at the edge ending the done cycle only if state is already IDLE, i.e. the earliest is the next edge after done.
- start while busy=1 is ignored, and captured operands are unaffected. No queueing.
- wb_we, wb_wa and wb_wd are 0 in IDLE and CALC.
- Destination 4'hF (PC): write suppressed (wb_we=0 for that word). State sequence and done timing are unchanged.
- Long op with wa_lo == wa_hi: both writes issued; the high word lands last and wins.
- Reset mid-operation (any state): return to IDLE next edge. The pending writeback is dropped and done does not pulse.
- Operand inputs are don't-care outside the start-accept edge.

Test Plan:
1. MUL a=7, b=6, wa_lo=3 -> busy=1 from E0. Cycle after E32: wb_we=1, wb_wa=3, wb_wd=42, done=1. busy=0 after E33.
2. UMULL a=b=0xFFFFFFFF, wa_lo=4, wa_hi=5 -> WB_LO writes 0x00000001 to r4, WB_HI writes 0xFFFFFFFE to r5. done only in the WB_HI cycle.
3. SMULL a=0xFFFFFFFE (-2), b=3, wa_lo=1, wa_hi=2 -> r1=0xFFFFFFFA, r2=0xFFFFFFFF. Also a=b=0x80000000 -> lo=0x00000000, hi=0x40000000.
4. MLA a=0x00010000, b=0x00010000, acc=5, wa_lo=6 -> wb_wd=0x00000005 (wrap). MLA a=3, b=4, acc=0xFFFFFFFF -> 0x0000000B.
5. MUL start, second start pulse with different operands at E10, rst=0 at E15 for one cycle -> second start ignored. IDLE after E15, no wb_we, no done. A fresh MUL a=2, b=2 started afterwards writes 4.
6. UMULL with wa_lo=15, wa_hi=7, a=b=0x00010000 -> WB_LO cycle has wb_we=0. WB_HI writes 0x00000001 to r7 with done=1.
